// File: rtl/control_sequencer.sv
// control_sequencer: T-state sequencer for a simple accumulator machine.
// Fetches each instruction in two cycles (T0 address, T1 read into IR),
// then runs one to three execute states picked by OPCODE.
// Optional build macro: ILLEGAL_TRAP_EN. When it is defined, undefined
// opcodes set ILLEGAL and halt; otherwise they execute as NOPs.
// Ports:
//   CLK     - system clock, rising edge
//   RESET   - asynchronous active-low reset
//   RUN     - enables instruction execution
//   PRGM    - program mode, forces the sequencer idle
//   OPCODE  - current instruction from the instruction register
//   ZERO    - accumulator-zero flag (used by JZ)
//   CTRL    - 14-bit control word, combinational from state/OPCODE/ZERO
//   TSTATE  - state code: IDLE=0, T0..T4=1..5, HALT=7
//   HALTED  - high while halted
//   ILLEGAL - sticky undefined-opcode flag
//   ICOUNT  - retired-instruction count, wraps
module control_sequencer #(
    parameter int unsigned ICNT_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RUN,
    input  logic              PRGM,
    input  logic [3:0]        OPCODE,
    input  logic              ZERO,
    output logic [13:0]       CTRL,
    output logic [2:0]        TSTATE,
    output logic              HALTED,
    output logic              ILLEGAL,
    output logic [ICNT_W-1:0] ICOUNT
);

    localparam int unsigned C_PC_OUT     = 0;
    localparam int unsigned C_PC_INC     = 1;
    localparam int unsigned C_PC_LOAD    = 2;
    localparam int unsigned C_MAR_LOAD   = 3;
    localparam int unsigned C_RAM_READ   = 4;
    localparam int unsigned C_RAM_WE     = 5;
    localparam int unsigned C_IR_LOAD    = 6;
    localparam int unsigned C_IR_ADDR_EN = 7;
    localparam int unsigned C_ACC_LOAD   = 8;
    localparam int unsigned C_ACC_OUT    = 9;
    localparam int unsigned C_B_LOAD     = 10;
    localparam int unsigned C_ALU_SUB    = 11;
    localparam int unsigned C_ALU_OUT    = 12;
    localparam int unsigned C_OUT_LOAD   = 13;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_HALT = 3'd7
    } state_e;

    state_e              state_q, state_d;
    logic [ICNT_W-1:0]   icount_q, icount_d;
    logic                done_c;    // current state is the instruction's last
`ifdef ILLEGAL_TRAP_EN
    logic                illegal_q, illegal_d;
`endif

    // Next state, control word and counter update
    always_comb begin
        state_d  = state_q;
        icount_d = icount_q;
        CTRL     = 14'h0000;
        done_c   = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (RUN) state_d = S_T0;
            end
            S_T0: begin
                CTRL[C_PC_OUT]   = 1'b1;
                CTRL[C_MAR_LOAD] = 1'b1;
                state_d          = S_T1;
            end
            S_T1: begin
                CTRL[C_RAM_READ] = 1'b1;
                CTRL[C_IR_LOAD]  = 1'b1;
                CTRL[C_PC_INC]   = 1'b1;
                state_d          = S_T2;
            end
            S_T2: begin
                case (OPCODE)
                    4'd0: done_c = 1'b1;
                    4'd1, 4'd2, 4'd3, 4'd4: begin
                        CTRL[C_IR_ADDR_EN] = 1'b1;
                        CTRL[C_MAR_LOAD]   = 1'b1;
                        state_d            = S_T3;
                    end
                    4'd5: begin
                        CTRL[C_IR_ADDR_EN] = 1'b1;
                        CTRL[C_PC_LOAD]    = 1'b1;
                        done_c             = 1'b1;
                    end
                    4'd6: begin
                        CTRL[C_IR_ADDR_EN] = ZERO;
                        CTRL[C_PC_LOAD]    = ZERO;
                        done_c             = 1'b1;
                    end
                    4'd14: begin
                        CTRL[C_ACC_OUT]  = 1'b1;
                        CTRL[C_OUT_LOAD] = 1'b1;
                        done_c           = 1'b1;
                    end
                    4'd15: state_d = S_HALT;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
`else
                        done_c    = 1'b1;
`endif
                    end
                endcase
            end
            S_T3: begin
                case (OPCODE)
                    4'd1: begin
                        CTRL[C_RAM_READ] = 1'b1;
                        CTRL[C_ACC_LOAD] = 1'b1;
                        done_c           = 1'b1;
                    end
                    4'd2, 4'd3: begin
                        CTRL[C_RAM_READ] = 1'b1;
                        CTRL[C_B_LOAD]   = 1'b1;
                        state_d          = S_T4;
                    end
                    4'd4: begin
                        CTRL[C_ACC_OUT] = 1'b1;
                        CTRL[C_RAM_WE]  = 1'b1;
                        done_c          = 1'b1;
                    end
                    // IR changed under us: end the instruction cleanly
                    default: done_c = 1'b1;
                endcase
            end
            S_T4: begin
                CTRL[C_ALU_OUT]  = 1'b1;
                CTRL[C_ACC_LOAD] = 1'b1;
                CTRL[C_ALU_SUB]  = (OPCODE == 4'd3);
                done_c           = 1'b1;
            end
            S_HALT: ;
            default: state_d = S_IDLE;
        endcase

        // Retire: RUN is only looked at on instruction boundaries
        if (done_c) begin
            state_d  = RUN ? S_T0 : S_IDLE;
            icount_d = icount_q + ICNT_W'(1);
        end

        // Program mode aborts anything in flight, nothing retires
        if (PRGM) begin
            state_d  = S_IDLE;
            icount_d = icount_q;
`ifdef ILLEGAL_TRAP_EN
            illegal_d = illegal_q;
`endif
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            icount_q <= '0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            icount_q <= icount_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign TSTATE = 3'(state_q);
    assign HALTED = (state_q == S_HALT);
    assign ICOUNT = icount_q;
`ifdef ILLEGAL_TRAP_EN
    assign ILLEGAL = illegal_q;
`else
    assign ILLEGAL = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed-vector bench for control_sequencer.
// Each vector sets the inputs for one clock cycle and queues the outputs
// expected during that cycle; a monitor pops and compares on the falling edge.
module tb_control_sequencer;

    localparam int unsigned ICW = 2;
`ifdef ILLEGAL_TRAP_EN
    localparam int TRAP = 1;
`else
    localparam int TRAP = 0;
`endif

    logic           CLK;
    logic           RESET;
    logic           RUN;
    logic           PRGM;
    logic [3:0]     OPCODE;
    logic           ZERO;
    logic [13:0]    CTRL;
    logic [2:0]     TSTATE;
    logic           HALTED;
    logic           ILLEGAL;
    logic [ICW-1:0] ICOUNT;

    control_sequencer #(.ICNT_W(ICW)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .RUN     (RUN),
        .PRGM    (PRGM),
        .OPCODE  (OPCODE),
        .ZERO    (ZERO),
        .CTRL    (CTRL),
        .TSTATE  (TSTATE),
        .HALTED  (HALTED),
        .ILLEGAL (ILLEGAL),
        .ICOUNT  (ICOUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0]    id;
        logic [2:0]     ts;
        logic [13:0]    ctrl;
        logic           h;
        logic           ill;
        logic [ICW-1:0] ic;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   vid   = 0;
    logic ill_e = 1'b0;
    int   icb;

    // Monitor: one queued expectation per cycle, checked mid-cycle
    initial begin
        forever begin
            @(negedge CLK);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                n_vec++;
                if ({TSTATE, CTRL, HALTED, ILLEGAL, ICOUNT} !==
                    {mon_e.ts, mon_e.ctrl, mon_e.h, mon_e.ill, mon_e.ic}) begin
                    n_err++;
                    $display("FAIL vec%0d: got ts=%0d ctrl=%h halted=%b illegal=%b icount=%0d, want ts=%0d ctrl=%h halted=%b illegal=%b icount=%0d",
                             mon_e.id, TSTATE, CTRL, HALTED, ILLEGAL, ICOUNT,
                             mon_e.ts, mon_e.ctrl, mon_e.h, mon_e.ill, mon_e.ic);
                end
            end
        end
    end

    task automatic step(input logic rst, input logic run, input logic prgm,
                        input int op, input logic z, input int ts, input int ctrl,
                        input logic h, input logic ill, input int ic);
        exp_t ent;
        @(posedge CLK);
        #1;
        RESET  = rst;
        RUN    = run;
        PRGM   = prgm;
        OPCODE = 4'(op);
        ZERO   = z;
        ent = {16'(vid), 3'(ts), 14'(ctrl), h, ill, ICW'(ic)};
        sb_q.push_back(ent);
        vid++;
    endtask

    // Normal cycle (reset released)
    task automatic cyc(input logic run, input logic prgm, input int op, input logic z,
                       input int ts, input int ctrl, input int ic);
        step(1'b1, run, prgm, op, z, ts, ctrl, (ts == 7), ill_e, ic);
    endtask

    // Fetch cycles T0/T1 with a junk opcode that must be ignored
    task automatic fetch(input int junk, input int ic);
        cyc(1'b1, 1'b0, junk, 1'b0, 1, 'h0009, ic);
        cyc(1'b1, 1'b0, junk ^ 'hF, 1'b1, 2, 'h0052, ic);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        RESET = 1'b0; RUN = 1'b1; PRGM = 1'b0; OPCODE = 4'd0; ZERO = 1'b0;
        icb = TRAP ? 2 : 3;

        // Reset held with RUN high, then release into IDLE
        step(1'b0, 1'b1, 1'b0, 5, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 2, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 2, 1'b0, 0, 'h0000, 0);
        // ADD
        fetch(7, 0);
        cyc(1'b1, 1'b0, 2, 1'b0, 3, 'h0088, 0);
        cyc(1'b1, 1'b0, 2, 1'b0, 4, 'h0410, 0);
        cyc(1'b1, 1'b0, 2, 1'b0, 5, 'h1100, 0);
        // SUB
        fetch(3, 1);
        cyc(1'b1, 1'b0, 3, 1'b0, 3, 'h0088, 1);
        cyc(1'b1, 1'b0, 3, 1'b0, 4, 'h0410, 1);
        cyc(1'b1, 1'b0, 3, 1'b0, 5, 'h1900, 1);
        // JZ not taken, JZ taken (count wraps 3 -> 0)
        fetch(9, 2);
        cyc(1'b1, 1'b0, 6, 1'b0, 3, 'h0000, 2);
        fetch(15, 3);
        cyc(1'b1, 1'b0, 6, 1'b1, 3, 'h0084, 3);
        // LDA, STA, JMP, OUT, NOP
        fetch(4, 0);
        cyc(1'b1, 1'b0, 1, 1'b0, 3, 'h0088, 0);
        cyc(1'b1, 1'b0, 1, 1'b0, 4, 'h0110, 0);
        fetch(1, 1);
        cyc(1'b1, 1'b0, 4, 1'b0, 3, 'h0088, 1);
        cyc(1'b1, 1'b0, 4, 1'b0, 4, 'h0220, 1);
        fetch(0, 2);
        cyc(1'b1, 1'b0, 5, 1'b0, 3, 'h0084, 2);
        fetch(6, 3);
        cyc(1'b1, 1'b0, 14, 1'b0, 3, 'h2200, 3);
        fetch(2, 0);
        cyc(1'b1, 1'b0, 0, 1'b0, 3, 'h0000, 0);
        // ADD with RUN dropped after T0: completes, then IDLE
        cyc(1'b1, 1'b0, 2, 1'b0, 1, 'h0009, 1);
        cyc(1'b0, 1'b0, 2, 1'b0, 2, 'h0052, 1);
        cyc(1'b0, 1'b0, 2, 1'b0, 3, 'h0088, 1);
        cyc(1'b0, 1'b0, 2, 1'b0, 4, 'h0410, 1);
        cyc(1'b0, 1'b0, 2, 1'b0, 5, 'h1100, 1);
        cyc(1'b0, 1'b0, 2, 1'b0, 0, 'h0000, 2);
        cyc(1'b1, 1'b0, 2, 1'b0, 0, 'h0000, 2);
        // LDA aborted by PRGM in T3; PRGM holds IDLE even with RUN
        fetch(1, 2);
        cyc(1'b1, 1'b0, 1, 1'b0, 3, 'h0088, 2);
        cyc(1'b1, 1'b1, 1, 1'b0, 4, 'h0110, 2);
        cyc(1'b1, 1'b1, 1, 1'b0, 0, 'h0000, 2);
        cyc(1'b1, 1'b0, 1, 1'b0, 0, 'h0000, 2);
        // Undefined opcode 9
        fetch(9, 2);
        cyc(1'b1, 1'b0, 9, 1'b0, 3, 'h0000, 2);
        if (TRAP != 0) begin
            ill_e = 1'b1;
            cyc(1'b1, 1'b1, 9, 1'b0, 7, 'h0000, 2);
            cyc(1'b1, 1'b0, 9, 1'b0, 0, 'h0000, 2);
        end
        // HLT: held 10 cycles with RUN high, PRGM exits to IDLE
        fetch(15, icb);
        cyc(1'b1, 1'b0, 15, 1'b0, 3, 'h0000, icb);
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 1'b0, i, i[0], 7, 'h0000, icb);
        cyc(1'b1, 1'b1, 0, 1'b0, 7, 'h0000, icb);
        cyc(1'b0, 1'b0, 0, 1'b0, 0, 'h0000, icb);
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 'h0000, icb);
        // Reset mid-instruction, restart at T0 after release
        fetch(2, icb);
        ill_e = 1'b0;
        step(1'b0, 1'b1, 1'b0, 2, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 2, 1'b0, 0, 'h0000, 0);
        cyc(1'b1, 1'b0, 2, 1'b0, 1, 'h0009, 0);
        cyc(1'b1, 1'b0, 2, 1'b0, 2, 'h0052, 0);

        @(posedge CLK);
        @(negedge CLK);
        #1;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d unchecked vectors, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter: ICNT_W, default 8, width of the retired-instruction counter.
REQ-002 SHALL have port: CLK  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port: RESET  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: RUN  input  1  enables instruction execution.
REQ-005 SHALL have port: PRGM  input  1  program mode; forces the sequencer idle.
REQ-006 SHALL have port: OPCODE  input  4  instruction from the instruction register's INST_OUT.
REQ-007 SHALL have port: ZERO  input  1  accumulator-zero flag.
REQ-008 SHALL have port: CTRL  output  14  control word: [0]PC_OUT [1]PC_INC [2]PC_LOAD [3]MAR_LOAD [4]RAM_READ [5]RAM_WE [6]IR_LOAD [7]IR_ADDR_EN [8]ACC_LOAD [9]ACC_OUT [10]B_LOAD [11]ALU_SUB [12]ALU_OUT [13]OUT_LOAD.
REQ-009 SHALL have port: TSTATE  output  3  state code: IDLE=0, T0..T4=1..5, HALT=7.
REQ-010 SHALL have port: HALTED  output  1  high in HALT.
REQ-011 SHALL have port: ILLEGAL  output  1  sticky undefined-opcode flag.
REQ-012 SHALL have port: ICOUNT  output  ICNT_W  retired-instruction count.

Function
REQ-013 SHALL implement states IDLE, T0, T1, T2, T3, T4, HALT; CTRL is a combinational function of state and OPCODE.
REQ-014 IDLE: CTRL=0; go to T0 when RUN=1 and PRGM=0.
REQ-015 T0: PC_OUT, MAR_LOAD; next T1.
REQ-016 T1: RAM_READ, IR_LOAD, PC_INC; next T2.
REQ-017 Opcodes in T2/T3/T4: 0 NOP (T2 none); 1 LDA (T2 IR_ADDR_EN+MAR_LOAD; T3 RAM_READ+ACC_LOAD); 2 ADD (T2 IR_ADDR_EN+MAR_LOAD; T3 RAM_READ+B_LOAD; T4 ALU_OUT+ACC_LOAD); 3 SUB (as ADD, ALU_SUB also high in T4); 4 STA (T2 IR_ADDR_EN+MAR_LOAD; T3 ACC_OUT+RAM_WE); 5 JMP (T2 IR_ADDR_EN+PC_LOAD); 6 JZ (T2 IR_ADDR_EN+PC_LOAD only if ZERO=1, else none); 14 OUT (T2 ACC_OUT+OUT_LOAD); 15 HLT (T2 none, next HALT).
REQ-018 After an opcode's last listed T-state, next state SHALL be T0 if RUN=1, else IDLE; instruction lengths: NOP/JMP/JZ/OUT 3, LDA/STA 4, ADD/SUB 5 cycles.
REQ-019 ICOUNT SHALL increment by 1 on the edge that ends each non-HLT instruction; wraps from all-ones to 0.
REQ-020 RUN deasserted mid-instruction SHALL NOT abort it; the instruction completes, then IDLE.
REQ-021 PRGM=1 SHALL force IDLE on the next edge from any state, including HALT, aborting any instruction without incrementing ICOUNT.
REQ-022 HALT: CTRL=0, HALTED=1; exits only on RESET or PRGM.
REQ-023 OPCODE SHALL be sampled only in T2..T4; values in IDLE/T0/T1 have no effect.

Reset
REQ-024 RESET=0 SHALL immediately force state IDLE, CTRL=0, TSTATE=0, HALTED=0, ILLEGAL=0, ICOUNT=0, independent of CLK.
REQ-025 Reset asserted mid-instruction SHALL abort it; execution restarts at T0 after release when RUN=1.

Configuration
REQ-026 With macro ILLEGAL_TRAP_EN defined, undefined opcodes (7..13) in T2 SHALL set ILLEGAL and go to HALT without incrementing ICOUNT.
REQ-027 Without ILLEGAL_TRAP_EN, undefined opcodes SHALL execute as NOP (3 cycles, ICOUNT increments) and ILLEGAL SHALL be tied to 0.

Verification
REQ-028 RESET low, RUN=1 -> TSTATE=0, CTRL=0, ICOUNT=0; release -> T0 next edge, CTRL=14'h0009.
REQ-029 OPCODE=2 (ADD) -> CTRL sequence T0 0x0009, T1 0x0052, T2 0x0088, T3 0x0410, T4 0x1100; ICOUNT +1 after 5 cycles.
REQ-030 OPCODE=6 with ZERO=0 -> T2 CTRL=0; with ZERO=1 -> T2 CTRL=0x0084; both return to T0.
REQ-031 OPCODE=15 -> HALT after T2, HALTED=1 held 10 cycles with RUN=1; PRGM=1 -> IDLE next edge.
REQ-032 PRGM=1 asserted during T3 of LDA -> IDLE next edge, ICOUNT unchanged; ICNT_W=2 with 4 NOPs -> ICOUNT wraps to 0.
REQ-033 OPCODE=9: with ILLEGAL_TRAP_EN -> ILLEGAL=1, HALT; without -> 3-cycle NOP, ILLEGAL=0.
